uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Downstream consumer of the SoC's debug byte port (out_byte / out_byte_en written at 0x2000_0000).
- Buffers bytes in a FIFO and serialises them on a single 8N1 UART TX line, so firmware print output reaches real hardware, not only simulation $write.
- The producer has no backpressure, so overflow is detected and flagged sticky.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per UART bit period; legal range 2..65535.
- FIFO_DEPTH, 16, FIFO entries; power of two, 2..256.

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- in_byte  input  8  byte to transmit
- in_byte_en  input  1  single-cycle strobe; in_byte valid
- overflow_clr  input  1  clears the sticky overflow flag
- tx  output  1  serial line, idle high
- busy  output  1  high when the FSM is not IDLE or the FIFO is not empty
- fifo_full  output  1  FIFO holds FIFO_DEPTH entries
- fifo_empty  output  1  FIFO holds 0 entries
- overflow  output  1  sticky; a byte was dropped

Behaviour:
- Reset (async assert, sync deassert at the use site) forces:
  - tx=1, busy=0, fifo_full=0, fifo_empty=1, overflow=0
  - FSM=IDLE; FIFO pointers and count=0
  - Mid-frame reset aborts the frame immediately; tx returns high.
- Push:
  - in_byte_en && !fifo_full at a rising edge writes in_byte at the tail.
  - in_byte_en && fifo_full drops the byte and sets overflow=1.
  - fifo_full is evaluated on the registered count, so a pop in the same cycle does not rescue the byte.
- Overflow flag:
  - overflow_clr clears overflow.
  - A drop in the same cycle as overflow_clr wins: overflow stays 1.
- Pop: only in IDLE with !fifo_empty. The head byte loads the shift register and the FSM goes to START.
- Simultaneous push and pop: count is unchanged and pointers each advance by one. This is legal even when the FIFO is full, provided the push was accepted under the registered-full rule.
- FSM states:
  - IDLE: tx=1; on !fifo_empty, pop and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each; bit index 0..7, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Outputs and counters:
  - tx is registered.
  - The bit-period counter counts 0..CLKS_PER_BIT-1 and wraps; its width is clog2(CLKS_PER_BIT).
- Latency:
  - tx falls at the edge after the edge that accepted the byte, when the FIFO was empty and the FSM was IDLE.
  - Back-to-back frames are separated by exactly one IDLE cycle.
  - One frame is 10*CLKS_PER_BIT cycles.
- Pointer wrap: modulo FIFO_DEPTH, with a count of width clog2(FIFO_DEPTH)+1.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even parity of the 8 data bits (XOR of the byte) for CLKS_PER_BIT cycles. A frame is then 11*CLKS_PER_BIT cycles.
- Undefined: no PARITY state or logic; the frame is 8N1 at 10*CLKS_PER_BIT cycles.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4)
  - DATA_BITS=8
  - idle line level constant
- One sub-module, sync_fifo (parameter FIFO_DEPTH, width 8). It provides push/pop, full/empty and count, with async active-low reset. This lets the same FIFO be reused by a later UART RX.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=16):
- Reset, no stimulus -> tx=1, busy=0, fifo_empty=1, overflow=0 for 100 cycles.
- Single byte 0x55 -> after the accept edge, tx = 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop), 4 cycles each. Then busy=0 and fifo_empty=1.
- Back-to-back 0xA3, 0x0F on consecutive cycles -> frame 1 (40 cycles), 1 idle cycle, frame 2 (40 cycles). Bit order checked by a bench UART receiver model; bytes arrive as 0xA3 then 0x0F.
- 18 consecutive pushes 0x00..0x11 -> 0x11 dropped and overflow=1 at that edge. Bytes 0x00..0x10 are received in order. overflow_clr pulse then clears overflow.
- resetn low for 1 cycle during DATA of byte 0xFF -> tx=1 immediately. After reset, FIFO empty, no remaining bits emitted, busy=0.
- With UART_TX_PARITY_EN: byte 0x07 -> parity bit 1, frame length 44 cycles. Byte 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM state encoding, data width and idle line level.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int unsigned DATA_BITS  = 8;
    localparam logic        IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count; push while full and pop while empty are ignored.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned WIDTH      = DATA_BITS
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        push,
    input  logic [WIDTH-1:0]            din,
    input  logic                        pop,
    output logic [WIDTH-1:0]            dout,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    // Full/empty come from the registered count, so a same-cycle pop never frees a slot.
    assign full  = (count == (AW + 1)'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter for the debug byte port, with sticky overflow flag.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] in_byte,
    input  logic       in_byte_en,
    input  logic       overflow_clr,
    output logic       tx,
    output logic       busy,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       overflow
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

    tx_state_t                 state;
    logic [CNT_W-1:0]          bit_cnt;
    logic [2:0]                bit_idx;
    logic [DATA_BITS-1:0]      shreg;
    logic [DATA_BITS-1:0]      fifo_dout;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                      pop;
    logic                      bit_end;
`ifdef UART_TX_PARITY_EN
    logic                      parity_bit;
`endif

    sync_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (DATA_BITS)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (in_byte_en),
        .din    (in_byte),
        .pop    (pop),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    assign pop     = (state == ST_IDLE) && !fifo_empty;
    assign bit_end = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign busy    = (state != ST_IDLE) || (fifo_count != '0);

    // A drop takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow <= 1'b0;
        end else if (in_byte_en && fifo_full) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    bit_cnt <= '0;
                    bit_idx <= '0;
                    tx      <= IDLE_LEVEL;
                    if (!fifo_empty) begin
                        shreg <= fifo_dout;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^fifo_dout;
`endif
                        tx    <= 1'b0;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        tx      <= shreg[0];
                        state   <= ST_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= parity_bit;
                            state <= ST_PARITY;
`else
                            tx    <= IDLE_LEVEL;
                            state <= ST_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        tx      <= IDLE_LEVEL;
                        state   <= ST_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        tx      <= IDLE_LEVEL;
                        state   <= ST_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    bit_cnt <= '0;
                    tx      <= IDLE_LEVEL;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-schedule reference model plus an offline UART receiver.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] in_byte;
    logic       in_byte_en;
    logic       overflow_clr;
    logic       tx;
    logic       busy;
    logic       fifo_full;
    logic       fifo_empty;
    logic       overflow;

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .in_byte      (in_byte),
        .in_byte_en   (in_byte_en),
        .overflow_clr (overflow_clr),
        .tx           (tx),
        .busy         (busy),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: each accepted byte gets a scheduled frame start edge.
    int         start_q[$];
    logic [7:0] byte_q[$];
    int         last_end;
    logic       m_ovf, m_drop;
    logic       exp_tx, exp_busy, exp_empty, exp_full;

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (NB == 11 && k == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic model_clear();
        start_q.delete();
        byte_q.delete();
        last_end = -1000;
        m_ovf    = 1'b0;
        m_drop   = 1'b0;
        exp_tx = 1'b1; exp_busy = 1'b0; exp_empty = 1'b1; exp_full = 1'b0;
    endtask

    task automatic tick(input logic en, input logic [7:0] b, input logic clr);
        int t, pending, s;
        in_byte_en   = en;
        in_byte      = b;
        overflow_clr = clr;
        @(posedge clk);
        cyc++;
        t = cyc;
        pending = 0;
        foreach (start_q[i]) if (start_q[i] >= t) pending++;
        m_drop = en && (pending == DEPTH);
        if (en && pending != DEPTH) begin
            s = (t + 1 > last_end + 1) ? t + 1 : last_end + 1;
            start_q.push_back(s);
            byte_q.push_back(b);
            last_end = s + NB * CPB;
        end
        if (m_drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        exp_tx = 1'b1; exp_busy = 1'b0; exp_empty = 1'b1; pending = 0;
        foreach (start_q[i]) begin
            if (t >= start_q[i] && t < start_q[i] + NB * CPB)
                exp_tx = frame_bit(byte_q[i], (t - start_q[i]) / CPB);
            if (t < start_q[i] + NB * CPB) exp_busy = 1'b1;
            if (start_q[i] > t) begin exp_empty = 1'b0; pending++; end
        end
        exp_full = (pending == DEPTH);
        #1;
    endtask

    task automatic test_reset();
        in_byte_en = 1'b0; in_byte = '0; overflow_clr = 1'b0;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        model_clear();
        cyc = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1'b0, 8'h00, 1'b0);
            n_vec++;
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_empty !== 1'b1 || overflow !== 1'b0 || fifo_full !== 1'b0) begin
                n_err++;
                $display("FAIL reset_idle cyc %0d: tx=%b busy=%b empty=%b full=%b ovf=%b, expected 1 0 1 0 0",
                         i, tx, busy, fifo_empty, fifo_full, overflow);
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] b;
        logic       want;
        b = 8'h55;
        tick(1'b1, b, 1'b0);
        for (int j = 0; j < NB * CPB; j++) begin
            tick(1'b0, 8'h00, 1'b0);
            want = frame_bit(b, j / CPB);
            n_vec++;
            if (tx !== want) begin
                n_err++;
                $display("FAIL single_tx bitcycle %0d: got %b expected %b", j, tx, want);
            end
        end
        tick(1'b0, 8'h00, 1'b0);
        n_vec++;
        if (busy !== 1'b0 || fifo_empty !== 1'b1 || tx !== 1'b1) begin
            n_err++;
            $display("FAIL single_done: busy=%b empty=%b tx=%b expected 0 1 1", busy, fifo_empty, tx);
        end
    endtask

    task automatic test_back_to_back();
        logic rec[$];
        int   i0, i1, idx;
        logic [7:0] got;
        tick(1'b1, 8'hA3, 1'b0);
        rec.push_back(tx);
        tick(1'b1, 8'h0F, 1'b0);
        rec.push_back(tx);
        for (int j = 0; j < 2 * NB * CPB + 8; j++) begin
            tick(1'b0, 8'h00, 1'b0);
            rec.push_back(tx);
            n_vec++;
            if (tx !== exp_tx || busy !== exp_busy || fifo_empty !== exp_empty) begin
                n_err++;
                $display("FAIL b2b_wave cyc %0d: tx/busy/empty=%b%b%b expected %b%b%b",
                         j, tx, busy, fifo_empty, exp_tx, exp_busy, exp_empty);
            end
        end
        i0 = -1;
        for (int i = 0; i < rec.size(); i++) if (i0 < 0 && rec[i] === 1'b0) i0 = i;
        i1 = -1;
        if (i0 >= 0)
            for (int i = i0 + NB * CPB; i < rec.size(); i++) if (i1 < 0 && rec[i] === 1'b0) i1 = i;
        n_vec++;
        if (i0 < 0 || i1 < 0 || (i1 - i0) !== NB * CPB + 1) begin
            n_err++;
            $display("FAIL b2b_gap: frame starts %0d and %0d, spacing %0d expected %0d",
                     i0, i1, i1 - i0, NB * CPB + 1);
        end
        for (int f = 0; f < 2; f++) begin
            got = '0;
            for (int k = 0; k < 8; k++) begin
                idx = ((f == 0) ? i0 : i1) + CPB / 2 + (k + 1) * CPB;
                if (idx >= 0 && idx < rec.size()) got[k] = rec[idx];
            end
            n_vec++;
            if (got !== ((f == 0) ? 8'hA3 : 8'h0F)) begin
                n_err++;
                $display("FAIL b2b_rx_byte%0d: got %h expected %h", f, got, (f == 0) ? 8'hA3 : 8'h0F);
            end
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 18; i++) begin
            tick(1'b1, 8'(i), 1'b0);
            n_vec++;
            if (overflow !== m_ovf || fifo_full !== exp_full) begin
                n_err++;
                $display("FAIL ovf_fill push %0d: ovf=%b full=%b expected %b %b", i, overflow, fifo_full, m_ovf, exp_full);
            end
            if (i == 17) begin
                n_vec++;
                if (overflow !== 1'b1) begin
                    n_err++;
                    $display("FAIL ovf_set: got %b expected 1", overflow);
                end
            end
        end
        for (int j = 0; j < 17 * (NB * CPB + 1) + 4; j++) begin
            tick(1'b0, 8'h00, 1'b0);
            n_vec++;
            if (tx !== exp_tx || fifo_full !== exp_full || overflow !== 1'b1) begin
                n_err++;
                $display("FAIL ovf_drain cyc %0d: tx=%b full=%b ovf=%b expected %b %b 1",
                         j, tx, fifo_full, overflow, exp_tx, exp_full);
            end
        end
        tick(1'b0, 8'h00, 1'b1);
        n_vec++;
        if (overflow !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clr: ovf=%b busy=%b expected 0 0", overflow, busy);
        end
    endtask

    task automatic test_mid_reset();
        tick(1'b1, 8'hFF, 1'b0);
        for (int j = 0; j < 2 * CPB + 2; j++) tick(1'b0, 8'h00, 1'b0);
        n_vec++;
        if (tx !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_data: tx=%b busy=%b expected 1 1 (data bit of FF)", tx, busy);
        end
        resetn = 1'b0;
        #1;
        n_vec++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_empty !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_async: tx=%b busy=%b empty=%b expected 1 0 1", tx, busy, fifo_empty);
        end
        @(posedge clk);
        cyc++;
        #1;
        resetn = 1'b1;
        model_clear();
        for (int j = 0; j < 12 * CPB; j++) begin
            tick(1'b0, 8'h00, 1'b0);
            n_vec++;
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_empty !== 1'b1) begin
                n_err++;
                $display("FAIL midrst_after cyc %0d: tx=%b busy=%b empty=%b expected 1 0 1", j, tx, busy, fifo_empty);
            end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] bytes [2];
        logic       par   [2];
        bytes[0] = 8'h07; par[0] = 1'b1;
        bytes[1] = 8'h03; par[1] = 1'b0;
        for (int f = 0; f < 2; f++) begin
            tick(1'b1, bytes[f], 1'b0);
            for (int j = 0; j < 44; j++) begin
                tick(1'b0, 8'h00, 1'b0);
                if (j == 9 * CPB + CPB / 2) begin
                    n_vec++;
                    if (tx !== par[f]) begin
                        n_err++;
                        $display("FAIL parity_bit byte %h: got %b expected %b", bytes[f], tx, par[f]);
                    end
                end
                if (j == 43) begin
                    n_vec++;
                    if (busy !== 1'b1) begin
                        n_err++;
                        $display("FAIL parity_len_last byte %h: busy=%b expected 1", bytes[f], busy);
                    end
                end
            end
            tick(1'b0, 8'h00, 1'b0);
            n_vec++;
            if (busy !== 1'b0 || tx !== 1'b1) begin
                n_err++;
                $display("FAIL parity_len_end byte %h: busy=%b tx=%b expected 0 1", bytes[f], busy, tx);
            end
        end
    endtask
`endif

    task automatic test_random();
        int pct;
        logic en, clr;
        for (int ph = 0; ph < 4; ph++) begin
            pct = (ph == 0) ? 3 : (ph == 1) ? 40 : (ph == 2) ? 10 : 80;
            for (int j = 0; j < 700; j++) begin
                en  = ($urandom_range(99) < pct);
                clr = ($urandom_range(15) == 0);
                tick(en, 8'($urandom), clr);
                n_vec++;
                if (tx !== exp_tx || busy !== exp_busy || fifo_empty !== exp_empty ||
                    fifo_full !== exp_full || overflow !== m_ovf) begin
                    n_err++;
                    $display("FAIL random ph%0d cyc %0d: tx/busy/empty/full/ovf=%b%b%b%b%b expected %b%b%b%b%b",
                             ph, j, tx, busy, fifo_empty, fifo_full, overflow,
                             exp_tx, exp_busy, exp_empty, exp_full, m_ovf);
                end
            end
        end
        for (int j = 0; j < (DEPTH + 1) * (NB * CPB + 1) + 4; j++) begin
            tick(1'b0, 8'h00, 1'b0);
            n_vec++;
            if (tx !== exp_tx || busy !== exp_busy || fifo_empty !== exp_empty || fifo_full !== exp_full) begin
                n_err++;
                $display("FAIL random_drain cyc %0d: tx/busy/empty/full=%b%b%b%b expected %b%b%b%b",
                         j, tx, busy, fifo_empty, fifo_full, exp_tx, exp_busy, exp_empty, exp_full);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_mid_reset();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
